// File: rtl/tank_arena_ctrl_if.sv
// Tank arena controller bus.
// Groups the map ROM load port, tank move request/grant signals, bullet
// resolution signals and the renderer wall read port.
//   slave  : the arena controller (drives map_addr, ready, grants, facing,
//            bullet result pulses and vid_wall)
//   master : the surrounding system (ROM, movers, bullet engines, renderer)
interface tank_arena_ctrl_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CW   = 4
);
    localparam int unsigned IDW = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Map ROM load
    logic [2*CW-1:0]     map_addr;
    logic                map_bit;
    logic                ready;
    // Tank moves
    logic [N_CH*CW-1:0]  tank_x;
    logic [N_CH*CW-1:0]  tank_y;
    logic [N_CH-1:0]     tank_req;
    logic [2*N_CH-1:0]   tank_dir;
    logic [N_CH-1:0]     tank_busy;
    logic [N_CH-1:0]     move_grant;
    logic [2*N_CH-1:0]   facing;
    // Bullets
    logic [N_CH-1:0]     bul_active;
    logic [N_CH*CW-1:0]  bul_x;
    logic [N_CH*CW-1:0]  bul_y;
    logic [2*N_CH-1:0]   bul_dir;
    logic [N_CH-1:0]     bul_wall;
    logic [N_CH-1:0]     bul_tank;
    logic [N_CH*IDW-1:0] bul_tank_id;
    logic [N_CH-1:0]     bul_edge;
    // Renderer
    logic [2*CW-1:0]     vid_addr;
    logic                vid_wall;

    modport slave (
        input  map_bit, tank_x, tank_y, tank_req, tank_dir, tank_busy,
               bul_active, bul_x, bul_y, bul_dir, vid_addr,
        output map_addr, ready, move_grant, facing, bul_wall, bul_tank,
               bul_tank_id, bul_edge, vid_wall
    );

    modport master (
        output map_bit, tank_x, tank_y, tank_req, tank_dir, tank_busy,
               bul_active, bul_x, bul_y, bul_dir, vid_addr,
        input  map_addr, ready, move_grant, facing, bul_wall, bul_tank,
               bul_tank_id, bul_edge, vid_wall
    );
endinterface

// File: rtl/tank_arena_ctrl.sv
// Tank arena controller.
// Loads the wall bitmap from the map ROM after reset, then scans one slot per
// cycle: slots 0..N_CH-1 arbitrate tank moves, slots N_CH..2*N_CH-1 resolve
// bullets (edge, wall with wall clearing, tank hit). All result pulses are
// registered one cycle after the slot is evaluated.
// Ports:
//   i_clk     system clock
//   i_resetn  asynchronous active-low reset
//   bus       tank_arena_ctrl_if slave (ROM load, tank moves, bullets, video read)
module tank_arena_ctrl #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CW       = 4,
    parameter int unsigned GRID_MAX = 12
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    tank_arena_ctrl_if.slave bus
);
    localparam int unsigned IDW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned AW    = 2 * CW;
    localparam int unsigned NCELL = 1 << AW;
    localparam int unsigned NSLOT = 2 * N_CH;
    localparam int unsigned SW    = $clog2(NSLOT);
    localparam logic [CW:0] GMAX  = (CW + 1)'(GRID_MAX);

    typedef enum logic {StLoad, StScan} state_e;

    state_e              r_state, w_state_next;
    logic [AW-1:0]       r_load_cnt;
    logic                r_ready;
    logic [SW-1:0]       r_slot;
    logic                r_map [NCELL];
    logic [N_CH-1:0]     r_claim_v;
    logic [AW-1:0]       r_claim_cell [N_CH];
    logic [N_CH-1:0]     r_busy_q;
    logic [N_CH-1:0]     r_grant, r_bul_wall, r_bul_tank, r_bul_edge;
    logic [2*N_CH-1:0]   r_facing;
    logic [N_CH*IDW-1:0] r_bul_id;
    logic                r_vid_wall;

    logic                w_is_bul;
    logic [SW-1:0]       w_idx;
    logic [CW-1:0]       w_cur_x, w_cur_y;
    logic [1:0]          w_dir;
    logic [CW:0]         w_tx, w_ty;
    logic                w_oob;
    logic [AW-1:0]       w_tcell;
    logic                w_tgt_wall;
    logic                w_hit_tank;
    logic [IDW-1:0]      w_hit_id;
    logic                w_claim_hit;
    logic                w_tank_eval, w_tank_ok, w_bul_eval;

    // Current slot decode, target cell and collision checks
    always_comb begin
        w_is_bul = (r_slot >= SW'(N_CH));
        w_idx    = w_is_bul ? (r_slot - SW'(N_CH)) : r_slot;
        if (w_is_bul) begin
            w_cur_x = bus.bul_x[w_idx*CW +: CW];
            w_cur_y = bus.bul_y[w_idx*CW +: CW];
            w_dir   = bus.bul_dir[w_idx*2 +: 2];
        end else begin
            w_cur_x = bus.tank_x[w_idx*CW +: CW];
            w_cur_y = bus.tank_y[w_idx*CW +: CW];
            w_dir   = bus.tank_dir[w_idx*2 +: 2];
        end

        // One extra bit so a step past GRID_MAX cannot wrap back into range
        w_tx  = {1'b0, w_cur_x};
        w_ty  = {1'b0, w_cur_y};
        w_oob = 1'b0;
        case (w_dir)
            2'd0: begin
                w_oob = (w_cur_y == '0);
                w_ty  = w_ty - 1'b1;
            end
            2'd1: begin
                w_ty  = w_ty + 1'b1;
                w_oob = (w_ty > GMAX);
            end
            2'd2: begin
                w_oob = (w_cur_x == '0);
                w_tx  = w_tx - 1'b1;
            end
            default: begin
                w_tx  = w_tx + 1'b1;
                w_oob = (w_tx > GMAX);
            end
        endcase
        w_tcell    = {w_ty[CW-1:0], w_tx[CW-1:0]};
        w_tgt_wall = r_map[w_tcell];

        // Descending scan so the lowest matching tank index wins
        w_hit_tank  = 1'b0;
        w_hit_id    = '0;
        w_claim_hit = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (k != int'(w_idx)) begin
                if (bus.tank_x[k*CW +: CW] == w_tx[CW-1:0] &&
                    bus.tank_y[k*CW +: CW] == w_ty[CW-1:0]) begin
                    w_hit_tank = 1'b1;
                    w_hit_id   = IDW'(k);
                end
                if (r_claim_v[k] && r_claim_cell[k] == w_tcell) begin
                    w_claim_hit = 1'b1;
                end
            end
        end

        w_tank_eval = (r_state == StScan) && !w_is_bul && bus.tank_req[w_idx] &&
                      !bus.tank_busy[w_idx] && !r_claim_v[w_idx];
        w_tank_ok   = w_tank_eval && !(w_oob || w_tgt_wall || w_hit_tank || w_claim_hit);
        w_bul_eval  = (r_state == StScan) && w_is_bul && bus.bul_active[w_idx];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StLoad:  if (&r_load_cnt) w_state_next = StScan;
            default: w_state_next = StScan;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= StLoad;
            r_load_cnt <= '0;
            r_ready    <= 1'b0;
            r_slot     <= '0;
            r_claim_v  <= '0;
            for (int k = 0; k < N_CH; k++) r_claim_cell[k] <= '0;
            r_busy_q   <= '0;
            r_grant    <= '0;
            r_bul_wall <= '0;
            r_bul_tank <= '0;
            r_bul_edge <= '0;
            r_facing   <= '0;
            r_bul_id   <= '0;
            r_vid_wall <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= '0;
            r_bul_wall <= '0;
            r_bul_tank <= '0;
            r_bul_edge <= '0;
            r_busy_q   <= bus.tank_busy;
            r_vid_wall <= r_map[bus.vid_addr];

            if (r_state == StLoad) begin
                r_load_cnt <= r_load_cnt + 1'b1;
                if (&r_load_cnt) r_ready <= 1'b1;
            end else begin
                r_slot <= (r_slot == SW'(NSLOT - 1)) ? '0 : r_slot + 1'b1;
            end

            // A claim holds the target cell until the mover finishes animating
            r_claim_v <= r_claim_v & ~(r_busy_q & ~bus.tank_busy);

            if (w_tank_eval) begin
                r_facing[w_idx*2 +: 2] <= w_dir;
                if (w_tank_ok) begin
                    r_grant[w_idx]      <= 1'b1;
                    r_claim_v[w_idx]    <= 1'b1;
                    r_claim_cell[w_idx] <= w_tcell;
                end
            end

            if (w_bul_eval) begin
                if (w_oob) begin
                    r_bul_edge[w_idx] <= 1'b1;
                end else if (w_tgt_wall) begin
                    r_bul_wall[w_idx] <= 1'b1;
                end else if (w_hit_tank) begin
                    r_bul_tank[w_idx]            <= 1'b1;
                    r_bul_id[w_idx*IDW +: IDW]   <= w_hit_id;
                end
            end
        end
    end

    // Bitmap is not reset: LOAD rewrites every cell
    always_ff @(posedge i_clk) begin
        if (r_state == StLoad) begin
            r_map[r_load_cnt] <= bus.map_bit;
        end else if (w_bul_eval && !w_oob && w_tgt_wall) begin
            r_map[w_tcell] <= 1'b0;
        end
    end

    assign bus.map_addr    = r_load_cnt;
    assign bus.ready       = r_ready;
    assign bus.move_grant  = r_grant;
    assign bus.facing      = r_facing;
    assign bus.bul_wall    = r_bul_wall;
    assign bus.bul_tank    = r_bul_tank;
    assign bus.bul_tank_id = r_bul_id;
    assign bus.bul_edge    = r_bul_edge;
    assign bus.vid_wall    = r_vid_wall;
endmodule

// File: doc/tank_arena_ctrl.md
Name: tank_arena_ctrl

Overview:
Parametrised successor of the fixed four-tank move checker. It holds the arena wall map in an internal bitmap, loaded from the map ROM after reset. It round-robin arbitrates N_CH tank move requests against the arena bounds, walls, other tanks and pending moves. It also resolves N_CH bullets against walls, bounds and tanks, and clears walls that bullets hit. It sits between the per-tank movers/bullet engines and the VGA renderer.

Parameters:
N_CH, 4, number of tanks; bullet j is owned by tank j.
CW, 4, cell coordinate width; the map has 2^(2*CW) cells.
GRID_MAX, 12, highest legal cell coordinate on each axis; must be < 2^CW.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
map_addr  out  2*CW  ROM address {y,x} during load
map_bit  in  1  ROM data for map_addr, same cycle (1 = wall)
ready  out  1  high once the map load is complete
tank_x, tank_y  in  N_CH*CW each  current cell of each tank, slice i = tank i
tank_req  in  N_CH  move request (level)
tank_dir  in  2*N_CH  requested direction: 0 up(y-1), 1 down(y+1), 2 left(x-1), 3 right(x+1)
tank_busy  in  N_CH  mover for tank i is animating
move_grant  out  N_CH  1-cycle grant pulse
facing  out  2*N_CH  last evaluated direction per tank
bul_active  in  N_CH  bullet j in flight
bul_x, bul_y  in  N_CH*CW each  bullet cell
bul_dir  in  2*N_CH  bullet direction, same encoding
bul_wall  out  N_CH  pulse: hit a wall, wall cleared
bul_tank  out  N_CH  pulse: hit a tank
bul_tank_id  out  N_CH*$clog2(N_CH)  victim index, valid with bul_tank
bul_edge  out  N_CH  pulse: left the arena
vid_addr  in  2*CW  renderer read address {y,x}
vid_wall  out  1  map bit at vid_addr, registered

Behaviour:
- Reset (async, resetn=0): state LOAD, load counter 0, slot 0, all pulses 0, facing 0, ready 0, claims cleared, vid_wall 0. The bitmap is not cleared; it is rewritten by LOAD. Reset mid-scan discards pending claims and reloads the map.
- LOAD: map_addr = counter; bitmap[counter] <= map_bit each cycle. After 2^(2*CW) cycles, go to SCAN; ready <= 1 and stays high.
- SCAN: slot counter runs 0..2*N_CH-1 and wraps, one slot per cycle. Slots 0..N_CH-1 are tanks; slots N_CH..2N_CH-1 are bullets.
- Target cell: the current cell stepped by dir. The target is out of bounds if the step would go below 0 or above GRID_MAX. No modular wrap.
- Tank slot i is evaluated only if tank_req[i]=1, tank_busy[i]=0 and claim[i]=0. Otherwise nothing happens.
  - facing[i] <= tank_dir[i] on every evaluation.
  - The move is blocked if any of these hold: out of bounds; the target's map bit is 1; the target equals the cell of any other tank; the target equals any valid claim of another tank.
  - If not blocked: move_grant[i] pulses the next cycle, and claim[i] <= {1, target}.
  - claim[i] clears on the first cycle tank_busy[i] is 1 and then 0 (falling edge), or at reset.
- Bullet slot j is evaluated only if bul_active[j]=1. Checks are applied in priority order, and only one pulse is issued per evaluation:
  1. Out of bounds: bul_edge[j].
  2. Wall at target: bitmap[target] <= 0 and bul_wall[j].
  3. Target equals the cell of tank k with k≠j: bul_tank[j] with bul_tank_id = lowest such k.
  4. Otherwise: no output.
- All pulses are registered, asserted exactly 1 cycle, and issued 1 cycle after the slot is evaluated. Grant-to-grant latency for a tank is at most 2*N_CH cycles.
- Simultaneous events: tanks targeting the same cell are resolved by slot order. The earlier slot claims the cell; the later one is blocked by the claim.
- A bullet clear and a vid read of the same cell in the same cycle: vid_wall returns the old value. The new value is visible from the next cycle.
- vid_wall <= bitmap[vid_addr] every cycle in all states. During LOAD it returns partially loaded data.

Test Plan:
- Load with a ROM that has walls only at {y=3,x=5} -> ready rises after 2^(2*CW) cycles. vid_addr={3,5} gives vid_wall=1 one cycle later; {3,4} gives 0.
- Tank0 at (4,3) requests right (target (5,3), wall) -> no move_grant, facing[0]=3. The same tank requesting down -> move_grant[0] pulses once.
- Tank0 at (0,0) requests up, and tank1 at (12,12) requests right -> both blocked, no grants.
- Tank0 at (2,2) requests right and tank1 at (4,2) requests left, both idle -> only move_grant[0]. Tank1 stays blocked until tank_busy[0] has risen then fallen.
- Bullet1 at (4,3) moving right -> bul_wall[1] pulse, then vid_wall at {3,5} reads 0. Re-evaluating (bullet still active) gives no further bul_wall.
- Bullet0 at (6,6) moving down with tank2 at (6,7) -> bul_tank[0]=1 and bul_tank_id slice = 2. Assert resetn mid-scan -> all pulses drop immediately, and LOAD restarts with the wall restored.
